// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between
// two byte requesters; owns the bit-rate enable divider.
module uart_tx_arbiter #(
  parameter int DIV   = 16,
  parameter int PHASE = 7,
  parameter int WDOG  = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       enable,
  output logic       shiftLoad,
  output logic [7:0] parallelOut,
  input  logic       txEmpty,
  output logic       busy,
  output logic       owner,
  output logic [7:0] frameCount,
  output logic       err
);

  localparam int WW = $clog2(WDOG + 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [3:0] PH = 4'(PHASE);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEND
  } state_t;

  state_t        state;
  state_t        stateNext;
  logic [3:0]    divider;
  logic [WW-1:0] wdog;
  logic [WW-1:0] wdogNext;
  logic          firstSend;
  logic          firstSendNext;
  logic          grant;
  logic          grantOwner;
  logic          shiftLoadNext;
  logic          ownerNext;
  logic          errNext;
  logic [7:0]    parallelNext;
  logic [7:0]    frameNext;

  assign enable = (divider == PH);
  assign busy   = (state != IDLE);

  // ack is the grant itself; reset gates it since req is still live
  assign ack0 = reset & grant & ~grantOwner;
  assign ack1 = reset & grant & grantOwner;

  always_comb begin
    grant      = 1'b0;
    grantOwner = owner;
    if (state == IDLE && txEmpty) begin
      unique case ({req1, req0})
        2'b01: begin
          grant      = 1'b1;
          grantOwner = 1'b0;
        end
        2'b10: begin
          grant      = 1'b1;
          grantOwner = 1'b1;
        end
        2'b11: begin
          grant      = 1'b1;
          grantOwner = ~owner;
        end
        default: grant = 1'b0;
      endcase
    end
  end

  always_comb begin
    stateNext     = state;
    wdogNext      = wdog;
    firstSendNext = 1'b0;
    shiftLoadNext = 1'b1;
    ownerNext     = owner;
    errNext       = err;
    parallelNext  = parallelOut;
    frameNext     = frameCount;
    unique case (state)
      IDLE: begin
        if (grant) begin
          stateNext     = ARMED;
          shiftLoadNext = 1'b0;
          ownerNext     = grantOwner;
          parallelNext  = grantOwner ? data1 : data0;
        end
      end
      ARMED: begin
        shiftLoadNext = 1'b0;
        if (enable) begin
          stateNext     = SEND;
          shiftLoadNext = 1'b1;
          wdogNext      = '0;
          firstSendNext = 1'b1;
        end
      end
      SEND: begin
        // txEmpty may be stale on the load edge, so skip that cycle
        if (!firstSend && txEmpty) begin
          stateNext = IDLE;
          frameNext = frameCount + 8'd1;
        end else if (enable) begin
          if (wdog == WD_LAST) begin
            stateNext = IDLE;
            errNext   = 1'b1;
          end else begin
            wdogNext = wdog + WW'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      divider     <= '0;
      wdog        <= '0;
      firstSend   <= 1'b0;
      shiftLoad   <= 1'b1;
      owner       <= 1'b1;
      err         <= 1'b0;
      parallelOut <= '0;
      frameCount  <= '0;
    end else begin
      state       <= stateNext;
      divider     <= (divider == DIV_LAST) ? 4'd0 : divider + 4'd1;
      wdog        <= wdogNext;
      firstSend   <= firstSendNext;
      shiftLoad   <= shiftLoadNext;
      owner       <= ownerNext;
      err         <= errNext;
      parallelOut <= parallelNext;
      frameCount  <= frameNext;
    end
  end

endmodule
